// File: rtl/logic_rx_pkg.sv
// Shared types and constants for the serial reduction receiver.
package logic_rx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_e;

  // Flag vector ordered {nor, nand, xnor, xor, or, and}
  typedef logic [5:0] flags_t;

  localparam int FLG_AND  = 0;
  localparam int FLG_OR   = 1;
  localparam int FLG_XOR  = 2;
  localparam int FLG_XNOR = 3;
  localparam int FLG_NAND = 4;
  localparam int FLG_NOR  = 5;

  // Flags of an all-zero word
  localparam flags_t FLAGS_RST = 6'b111000;

endpackage

// File: rtl/logic_reduce_unit.sv
// Combinational evaluation of all six reduction operators over one word.
module logic_reduce_unit
  import logic_rx_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] word_i,
  output flags_t           flags_o
);

  always_comb begin
    flags_o           = '0;
    flags_o[FLG_AND]  = &word_i;
    flags_o[FLG_OR]   = |word_i;
    flags_o[FLG_XOR]  = ^word_i;
    flags_o[FLG_XNOR] = ~^word_i;
    flags_o[FLG_NAND] = ~&word_i;
    flags_o[FLG_NOR]  = ~|word_i;
  end

endmodule

// File: rtl/logic_reduce_rx.sv
// LSB-first serial deserializer with reduction flags on a valid/ready output.
// Define LOGIC_RX_PARITY_EN to append a trailing even-parity bit and drive out_perr.
module logic_reduce_rx
  import logic_rx_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_word,
  output logic             out_and,
  output logic             out_or,
  output logic             out_xor,
  output logic             out_xnor,
  output logic             out_nand,
  output logic             out_nor,
  output logic             out_perr
);

  localparam int CNT_W = $clog2(WIDTH + 1);
`ifdef LOGIC_RX_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] word_q;
  flags_t           flags_q, flags_calc;
  logic             accept, last_bit, handshake;

  assign accept    = in_valid & in_ready;
  assign last_bit  = accept && (count_q == CNT_W'(FRAME_LEN - 1));
  assign handshake = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)    state_d = SHIFT;
      SHIFT:   if (last_bit)  state_d = HOLD;
      HOLD:    if (handshake) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE:    in_ready  = 1'b1;
      SHIFT:   in_ready  = 1'b1;
      HOLD:    out_valid = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (handshake)   count_d = '0;
    else if (accept) count_d = count_q + CNT_W'(1);
  end

  // Per-bit write enable; a parity bit (count==WIDTH) matches no position
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shift
    assign shift_d[gi] = handshake ? 1'b0 :
                         (accept && (count_q == CNT_W'(gi))) ? in_bit : shift_q[gi];
  end

  // Fed with the assembled word so flags reflect the bit accepted this cycle
  logic_reduce_unit #(.WIDTH(WIDTH)) u_reduce (
    .word_i  (shift_d),
    .flags_o (flags_calc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      shift_q <= '0;
      word_q  <= '0;
      flags_q <= FLAGS_RST;
    end else begin
      count_q <= count_d;
      shift_q <= shift_d;
      if (last_bit) begin
        word_q  <= shift_d;
        flags_q <= flags_calc;
      end
    end
  end

`ifdef LOGIC_RX_PARITY_EN
  logic perr_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           perr_q <= 1'b0;
    else if (last_bit) perr_q <= (^shift_d) ^ in_bit;
  end
  assign out_perr = perr_q;
`else
  assign out_perr = 1'b0;
`endif

  assign out_word = word_q;
  assign out_and  = flags_q[FLG_AND];
  assign out_or   = flags_q[FLG_OR];
  assign out_xor  = flags_q[FLG_XOR];
  assign out_xnor = flags_q[FLG_XNOR];
  assign out_nand = flags_q[FLG_NAND];
  assign out_nor  = flags_q[FLG_NOR];

endmodule
